seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//   Iterative unsigned restoring divider, inverse of the 4x4 array multiplier
//   datapath: dividend / divisor -> quotient, remainder. Produces one quotient bit
//   per clock. Sits beside the multiplier on the ui_in/uo_out datapath.
//   Start/done handshake.
// PARAMETERS
//   DIVIDEND_W  8  dividend and quotient width (bits)
//   DIVISOR_W   4  divisor and remainder width (bits)
// PORTS
//   clk          in   1           single clock, all state on rising edge
//   rst          in   1           synchronous reset, active-high
//   start        in   1           request a divide; sampled only when ready=1
//   dividend     in   DIVIDEND_W  operand, captured on accepting edge
//   divisor      in   DIVISOR_W   operand, captured on accepting edge
//   ready        out  1           high in IDLE or DONE (start will be accepted)
//   busy         out  1           high in RUN
//   done         out  1           one-cycle pulse, results valid
//   quotient     out  DIVIDEND_W  result, held until next accepted start
//   remainder    out  DIVISOR_W   result, held until next accepted start
//   div_by_zero  out  1           divisor was 0; held with results
// BEHAVIOUR
//   Reset: state=IDLE; ready=1; busy=0; done=0; quotient=0; remainder=0;
//     div_by_zero=0; step counter=0. Reset mid-RUN aborts with no done pulse.
//   FSM: IDLE -> RUN (start & divisor!=0) | DONE (start & divisor==0);
//     RUN -> DONE after DIVIDEND_W steps; DONE -> IDLE, or RUN/DONE if start.
//   Accepting edge N: latch operands; partial remainder PR (DIVISOR_W+1 bits)=0;
//     quotient shift reg=dividend; counter=DIVIDEND_W-1; div_by_zero cleared.
//   Each RUN edge: T={PR[DIVISOR_W-1:0], Q[MSB]}; Q<<=1;
//     if T>=divisor {PR=T-divisor; Q[0]=1} else {PR=T; Q[0]=0}; counter--.
//   Edges N+1..N+DIVIDEND_W perform steps; last step also enters DONE.
//   done high in the cycle after edge N+DIVIDEND_W (latency DIVIDEND_W clocks).
//   Divide by zero: skip RUN; done in the cycle after edge N; quotient=all ones;
//     remainder=dividend[DIVISOR_W-1:0]; div_by_zero=1.
//   start while busy: ignored, no effect on operands or count.
//   start during DONE: accepted (back-to-back); done still pulses 1 cycle only.
//   quotient/remainder outputs update only on entry to DONE, stable otherwise.
//   Invariant on done: quotient*divisor+remainder==dividend, remainder<divisor.
// CONFIGURATION
//   DIVIDER_SELFCHECK_EN defined: adds output check_ok (1 bit, reset 0);
//     on entry to DONE, registers (quotient*divisor + remainder == dividend)
//     using a combinational array multiply; forced 1 when div_by_zero.
//   Undefined: no check_ok port, no multiplier logic; behaviour otherwise same.
// STRUCTURE
//   Package div_pkg: DIVIDEND_W/DIVISOR_W defaults, state enum
//     {IDLE, RUN, DONE}, counter width constant $clog2(DIVIDEND_W).
//   Sub-module div_step: combinational single restoring step
//     (PR, next bit, divisor) -> (PR', quotient bit); instantiated once.
//   Top holds FSM, counter, operand/result registers.
// TESTING
//   200/7: start for 1 clk -> done exactly 8 clks later, q=28, r=4, dbz=0.
//   255/1 then 13/15 back-to-back (start in DONE) -> q=255 r=0; q=0 r=13.
//   37/0 -> done 1 clk after accept, q=255, r=5, div_by_zero=1.
//   Start 100/3, pulse start with 9/2 at step 3 -> ignored; q=33 r=1.
//   Start 250/9, assert rst at step 4 -> outputs at reset values, no done;
//     new start 250/9 -> q=27, r=7.
//   Exhaustive all 8-bit/4-bit pairs vs reference model; check_ok=1 when _EN.

Source files
------------

// File: rtl/div_pkg.sv
// Shared defaults, FSM encoding and counter width for the sequential restoring divider.
package div_pkg;
  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;
  localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   pr_in,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_out,
  output logic                 q_bit
);
  logic [DIVISOR_W:0] t;

  assign t = {pr_in[DIVISOR_W-1:0], next_bit};
  // PR stays below the divisor, so its top bit is zero; OR-ing it keeps the step
  // correct even if that ever stopped holding.
  assign q_bit  = pr_in[DIVISOR_W] | (t >= {1'b0, divisor});
  assign pr_out = q_bit ? (t - {1'b0, divisor}) : t;
endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional DIVIDER_SELFCHECK_EN adds check_ok: registered q*d+r==dividend on entry to DONE.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
`ifdef DIVIDER_SELFCHECK_EN
  ,
  output logic                  check_ok
`endif
);
  localparam int CNT_W = $clog2(DIVIDEND_W);

  state_t                state, nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W:0]    pr, pr_nxt;
  logic [DIVIDEND_W-1:0] q_sr, q_nxt;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic                  q_bit, accept, dz, last;

  assign accept = start & ready;
  assign dz     = (divisor == '0);
  assign last   = (state == RUN) && (cnt == '0);
  assign q_nxt  = {q_sr[DIVIDEND_W-2:0], q_bit};

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .pr_in   (pr),
    .next_bit(q_sr[DIVIDEND_W-1]),
    .divisor (dvs_q),
    .pr_out  (pr_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) nxt = dz ? DONE : RUN;
        else       nxt = IDLE;
      end
      RUN:     if (cnt == '0) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state != RUN);
    busy  = (state == RUN);
    done  = (state == DONE);
  end

  // Divide by zero short-circuits straight to the all-ones/low-bits result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      pr          <= '0;
      q_sr        <= '0;
      dvs_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt         <= CNT_W'(DIVIDEND_W - 1);
      pr          <= '0;
      q_sr        <= dividend;
      dvs_q       <= divisor;
      div_by_zero <= dz;
      if (dz) begin
        quotient  <= '1;
        remainder <= dividend[DIVISOR_W-1:0];
      end
    end else if (state == RUN) begin
      cnt  <= cnt - 1'b1;
      pr   <= pr_nxt;
      q_sr <= q_nxt;
      if (last) begin
        quotient  <= q_nxt;
        remainder <= pr_nxt[DIVISOR_W-1:0];
      end
    end
  end

`ifdef DIVIDER_SELFCHECK_EN
  localparam int PW = DIVIDEND_W + DIVISOR_W;

  logic [DIVIDEND_W-1:0] dvd_q;
  logic [PW-1:0]         prod, sum;

  // Shift-and-add array multiply of the final quotient by the latched divisor.
  always_comb begin
    prod = '0;
    for (int i = 0; i < DIVISOR_W; i++)
      if (dvs_q[i]) prod = prod + (PW'(q_nxt) << i);
    sum = prod + PW'(pr_nxt[DIVISOR_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q    <= '0;
      check_ok <= 1'b0;
    end else if (accept) begin
      dvd_q <= dividend;
      if (dz) check_ok <= 1'b1;
    end else if (last) begin
      check_ok <= (sum == PW'(dvd_q));
    end
  end
`endif
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, exhaustive and random
// divides against a plain-arithmetic model. Define DIVIDER_SELFCHECK_EN to also check check_ok.
module tb_seq_restoring_divider;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       ready, busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIVIDER_SELFCHECK_EN
  logic       check_ok;
`endif

  int n_chk = 0;
  int n_err = 0;
  int lat;

  seq_restoring_divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
`ifdef DIVIDER_SELFCHECK_EN
    ,
    .check_ok   (check_ok)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: integer division; divide by zero gives all ones and the low dividend bits.
  function automatic void ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin q = 255; r = a % 16; z = 1; end
    else        begin q = a / b; r = a % b; z = 0; end
  endfunction

  // Caller is at a negedge; presents operands for one accepting edge.
  task automatic issue(input int a, input int b);
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
  endtask

  task automatic wait_done();
    while (!done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_res(input int a, input int b);
    int q, r, z;
    ref_div(a, b, q, r, z);
    chk("latency", lat, (b == 0) ? 0 : 8);
    chk("done", done, 1);
    chk("quotient", quotient, q);
    chk("remainder", remainder, r);
    chk("div_by_zero", div_by_zero, z);
    chk("ready_in_done", ready, 1);
`ifdef DIVIDER_SELFCHECK_EN
    chk("check_ok", check_ok, 1);
`endif
  endtask

  task automatic div_one(input int a, input int b);
    issue(a, b);
    wait_done();
    check_res(a, b);
  endtask

  initial begin
    int saw;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
`ifdef DIVIDER_SELFCHECK_EN
    chk("rst_check_ok", check_ok, 0);
`endif

    // 200/7 with a one-cycle start, then done must be a single-cycle pulse
    issue(200, 7);
    chk("run_busy", busy, 1);
    chk("run_ready", ready, 0);
    wait_done();
    check_res(200, 7);
    @(posedge clk);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("hold_quotient", quotient, 28);

    // back-to-back: second start presented while done is high
    div_one(255, 1);
    div_one(13, 15);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_done_pulse", done, 0);

    div_one(37, 0);
    @(negedge clk);

    // start while busy is ignored; previous results held during RUN
    issue(100, 3);
    chk("held_q_in_run", quotient, 255);
    chk("held_dbz_in_run", div_by_zero, 0);
    repeat (2) begin @(posedge clk); @(negedge clk); lat++; end
    dividend = 8'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat++;
    start = 1'b0;
    wait_done();
    check_res(100, 3);
    @(negedge clk);

    // reset mid-run aborts with no done pulse
    issue(250, 9);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    saw = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (done) saw = 1;
    end
    chk("abort_no_done", saw, 0);
    div_one(250, 9);

    // exhaustive, back-to-back
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        div_one(a, b);

    // random operands with random idle gaps
    for (int k = 0; k < 300; k++) begin
      int a, b, gap;
      a   = int'($urandom_range(255, 0));
      b   = int'($urandom_range(15, 0));
      gap = int'($urandom_range(2, 0));
      repeat (gap) @(negedge clk);
      div_one(a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
